// File: rtl/memory_stage.sv
// Memory stage of a 5-stage RV32I pipeline: EX/MEM and MEM/WB registers around a 256x32 byte-lane data memory.
// Optional misaligned-access trap enabled by defining MEMORY_STAGE_MISALIGN_TRAP_EN.
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_data,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] mem_forward_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        misalign_err
);

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
  } ex_mem_t;

  ex_mem_t     em_q;
  logic [31:0] mem [256];

  logic [7:0]  word_idx;
  logic [31:0] rd_word;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        misalign_hit;
  logic        store_en;
  logic [3:0]  byte_en;
  logic [31:0] write_data;
  logic [31:0] shifted;
  logic [15:0] load_half;
  logic [31:0] load_fmt;
  logic [31:0] wb_next;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rw_q;
  logic [31:0] wb_data_q;
  logic        misalign_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      em_q <= '0;
    end else if (flush && stall) begin
      em_q.valid <= 1'b0;
    end else if (!stall) begin
      em_q.valid      <= ex_valid && !flush;
      em_q.alu        <= ex_alu_data;
      em_q.store_data <= ex_store_data;
      em_q.rd         <= ex_rd;
      em_q.reg_write  <= ex_reg_write;
      em_q.mem_read   <= ex_mem_read;
      em_q.mem_write  <= ex_mem_write;
      em_q.funct3     <= ex_funct3;
    end
  end

  assign word_idx = em_q.alu[9:2];
  assign rd_word  = mem[word_idx];
  assign is_byte  = (em_q.funct3[1:0] == 2'b00);
  assign is_half  = (em_q.funct3[1:0] == 2'b01);

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  assign misaligned = is_half ? em_q.alu[0] : (!is_byte && (em_q.alu[1:0] != 2'b00));
`else
  // Without the trap, ignored low address bits simply make the access aligned.
  assign misaligned = 1'b0;
`endif

  assign misalign_hit = em_q.valid && (em_q.mem_read || em_q.mem_write) && misaligned;
  assign store_en     = em_q.valid && em_q.mem_write && !stall && !reset && !misaligned;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_en    = 4'b1111;
    write_data = em_q.store_data;
    if (is_byte) begin
      byte_en    = 4'b0001 << em_q.alu[1:0];
      write_data = {4{em_q.store_data[7:0]}};
    end else if (is_half) begin
      byte_en    = em_q.alu[1] ? 4'b1100 : 4'b0011;
      write_data = {2{em_q.store_data[15:0]}};
    end
  end

  // NOTE: the data memory has no reset; its contents are only defined once written.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  assign shifted   = rd_word >> {em_q.alu[1:0], 3'b000};
  assign load_half = em_q.alu[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_fmt = rd_word;
    case (em_q.funct3)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
      3'b101:  load_fmt = {16'h0, load_half};
      default: load_fmt = rd_word;
    endcase
  end

  // A read+write entry behaves as a store, so it returns the ALU value.
  assign wb_next = (em_q.mem_read && !em_q.mem_write) ? load_fmt : em_q.alu;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else if (stall) begin
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= em_q.valid;
      wb_rd_q    <= em_q.rd;
      wb_rw_q    <= em_q.reg_write && !misalign_hit;
      wb_data_q  <= wb_next;
      misalign_q <= misalign_hit;
    end
  end

  assign mem_forward_data = em_q.alu;
  assign mem_rd           = em_q.rd;
  assign mem_reg_write    = em_q.valid && em_q.reg_write;
  assign wb_valid         = wb_valid_q;
  assign wb_rd            = wb_rd_q;
  assign wb_reg_write     = wb_valid_q && wb_rw_q;
  assign wb_data          = wb_data_q;
  assign misalign_err     = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; expectations adapt to MEMORY_STAGE_MISALIGN_TRAP_EN.
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu_data;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        stall;
  logic        flush;
  logic [31:0] mem_forward_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

`ifdef MEMORY_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  memory_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_alu_data      (ex_alu_data),
    .ex_store_data    (ex_store_data),
    .ex_rd            (ex_rd),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_funct3        (ex_funct3),
    .stall            (stall),
    .flush            (flush),
    .mem_forward_data (mem_forward_data),
    .mem_rd           (mem_rd),
    .mem_reg_write    (mem_reg_write),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_reg_write     (wb_reg_write),
    .wb_data          (wb_data),
    .misalign_err     (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fwd"},  mem_forward_data,     32'h0);
    check({tag, "_mrd"},  32'(mem_rd),          32'h0);
    check({tag, "_mrw"},  32'(mem_reg_write),   32'h0);
    check({tag, "_wbv"},  32'(wb_valid),        32'h0);
    check({tag, "_wrd"},  32'(wb_rd),           32'h0);
    check({tag, "_wrw"},  32'(wb_reg_write),    32'h0);
    check({tag, "_wdat"}, wb_data,              32'h0);
    check({tag, "_err"},  32'(misalign_err),    32'h0);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] f3);
    ex_valid      = v;
    ex_alu_data   = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_funct3     = f3;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;

    // Store word, then load it back on the following cycle.
    drive(1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010); tick();
    check("sw_fwd", mem_forward_data, 32'h10);
    check("sw_mrw", 32'(mem_reg_write), 32'h0);
    drive(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010); tick();
    check("lw_mrd", 32'(mem_rd), 32'h5);
    check("lw_mrw", 32'(mem_reg_write), 32'h1);
    idle(); tick();
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_wrd", 32'(wb_rd), 32'h5);
    check("lw_wrw", 32'(wb_reg_write), 32'h1);
    check("lw_wbv", 32'(wb_valid), 32'h1);

    // Sub-word load formatting, back to back.
    drive(1'b1, 32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000); tick();
    drive(1'b1, 32'h13, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b100); tick();
    check("lb", wb_data, 32'hFFFFFFDE);
    drive(1'b1, 32'h10, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101); tick();
    check("lbu", wb_data, 32'h000000DE);
    drive(1'b1, 32'h12, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b001); tick();
    check("lhu", wb_data, 32'h0000BEEF);
    idle(); tick();
    check("lh", wb_data, 32'hFFFFDEAD);

    // Byte store into lane 1, ALU pass-through, read+write treated as store.
    drive(1'b1, 32'h11, 32'hAAAAAA55, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000); tick();
    drive(1'b1, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010); tick();
    check("sb_wrw", 32'(wb_reg_write), 32'h0);
    drive(1'b1, 32'h1234, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("sb_lw", wb_data, 32'hDEAD55EF);
    drive(1'b1, 32'h40, 32'h5A5A5A5A, 5'd9, 1'b1, 1'b1, 1'b1, 3'b010); tick();
    check("alu_data", wb_data, 32'h1234);
    idle(); tick();
    check("rw_data", wb_data, 32'h40);
    drive(1'b1, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010); tick();
    idle(); tick();
    check("rw_stored", wb_data, 32'h5A5A5A5A);

    // Store held in EX/MEM by a three-cycle stall.
    drive(1'b1, 32'h20, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010); tick();
    stall = 1'b1;
    drive(1'b1, 32'hABC, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_fwd", mem_forward_data, 32'h20);
      check("stall_wbv", 32'(wb_valid), 32'h0);
      check("stall_err", 32'(misalign_err), 32'h0);
    end
    stall = 1'b0;
    drive(1'b1, 32'h20, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010); tick();
    check("rel_wbv", 32'(wb_valid), 32'h1);
    check("rel_data", wb_data, 32'h20);
    idle(); tick();
    check("rel_lw", wb_data, 32'h11111111);

    // Flush squashes an entry with reg_write set.
    flush = 1'b1;
    drive(1'b1, 32'h99, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    flush = 1'b0;
    check("flush_mrw", 32'(mem_reg_write), 32'h0);
    check("flush_mrd", 32'(mem_rd), 32'd12);
    idle(); tick();
    check("flush_wrw", 32'(wb_reg_write), 32'h0);
    check("flush_wbv", 32'(wb_valid), 32'h0);

    // Flush together with stall clears only EX/MEM valid.
    drive(1'b1, 32'h77, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("fs_pre_mrw", 32'(mem_reg_write), 32'h1);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h88, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0, 3'b000); tick();
    check("fs_mrw", 32'(mem_reg_write), 32'h0);
    check("fs_mrd", 32'(mem_rd), 32'd13);
    check("fs_fwd", mem_forward_data, 32'h77);
    stall = 1'b0; flush = 1'b0;
    idle(); tick();
    check("fs_wrw", 32'(wb_reg_write), 32'h0);
    check("fs_wrd", 32'(wb_rd), 32'd13);

    // Misaligned word store, then misaligned half load.
    drive(1'b1, 32'h12, 32'h77777777, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010); tick();
    drive(1'b1, 32'h10, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010); tick();
    check("mis_sw_err", 32'(misalign_err), TRAP ? 32'h1 : 32'h0);
    drive(1'b1, 32'h11, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b001); tick();
    check("mis_lw_err", 32'(misalign_err), 32'h0);
    check("mis_lw_data", wb_data, TRAP ? 32'hDEAD55EF : 32'h77777777);
    idle(); tick();
    check("mis_lh_err", 32'(misalign_err), TRAP ? 32'h1 : 32'h0);
    check("mis_lh_wrw", 32'(wb_reg_write), TRAP ? 32'h0 : 32'h1);
    idle(); tick();
    check("mis_clear", 32'(misalign_err), 32'h0);

    // Reset with a store pending in EX/MEM.
    drive(1'b1, 32'h30, 32'h01010101, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010); tick();
    drive(1'b1, 32'h30, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010); tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0;
    check_zero("rst_store");
    drive(1'b1, 32'h30, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010); tick();
    idle(); tick();
    check("rst_nowrite", wb_data, 32'h01010101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the ports are clk and reset.
REQ-002 SHALL provide these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- ex_valid  in  1  execute result valid
- ex_alu_data  in  32  ALU result / effective address
- ex_store_data  in  32  forwarded rs2 store data
- ex_rd  in  5  destination register
- ex_reg_write  in  1  register write enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign (RV32I encoding)
- stall  in  1  hold both pipeline registers
- flush  in  1  squash incoming execute result
- mem_forward_data  out  32  EX/MEM ALU result, for forwarding
- mem_rd  out  5  EX/MEM rd
- mem_reg_write  out  1  EX/MEM valid AND reg_write
- wb_valid  out  1  MEM/WB valid
- wb_rd  out  5  MEM/WB rd
- wb_reg_write  out  1  MEM/WB valid AND reg_write
- wb_data  out  32  write-back data
- misalign_err  out  1  one-cycle misaligned-access pulse

Function
REQ-003 SHALL hold an EX/MEM register (valid, alu, store data, rd, reg_write, mem_read, mem_write, funct3); it loads the ex_* inputs at each edge when stall=0.
REQ-004 SHALL load EX/MEM valid as ex_valid AND NOT flush; flush has priority over stall, and flush with stall=1 clears only EX/MEM valid.
REQ-005 SHALL contain 256x32 data memory, word index = alu[9:2]; upper address bits ignored; memory not reset.
REQ-006 SHALL read memory combinationally from the EX/MEM address and capture the result into a MEM/WB register at the next edge when stall=0; load-to-wb_data latency = 2 edges after ex_* presented.
REQ-007 SHALL, on store (EX/MEM valid, mem_write, stall=0, not suppressed), write at the clock edge using byte lanes:
- funct3 000: lane alu[1:0], data[7:0]
- funct3 001: lanes 2*alu[1]..+1, data[15:0]
- other codes: all lanes
REQ-008 SHALL format loads as follows:
- 000: byte sign-extended
- 100: byte zero-extended
- 001: half sign-extended
- 101: half zero-extended
- other codes: full word
REQ-009 SHALL set wb_data = formatted load when mem_read=1, else the EX/MEM alu value.
REQ-010 SHALL treat mem_read=1 and mem_write=1 together as a store only; wb_data = alu.
REQ-011 SHALL return the newly stored data to a load issued on the cycle after a store to the same word (write-then-read ordering).
REQ-012 SHALL, when stall=1, perform no store, hold both registers, and hold misalign_err at 0.
REQ-013 SHALL drive mem_* outputs from the EX/MEM register and wb_* outputs from the MEM/WB register; MEM/WB valid = EX/MEM valid.

Reset
REQ-014 SHALL, on reset=1 at an edge, clear both valid bits, all register fields, and misalign_err to 0; all outputs read 0 the cycle after.
REQ-015 SHALL give reset priority over stall and flush, and a store pending in EX/MEM at the reset edge SHALL NOT be written.

Configuration
REQ-016 SHALL support macro MEMORY_STAGE_MISALIGN_TRAP_EN:
- Defined: half with alu[0]=1 or word with alu[1:0]!=0 suppresses the store, forces wb_reg_write=0 for that entry, and pulses misalign_err for one cycle aligned with the wb_* outputs.
- Undefined: misalign_err is tied 0, the offending low address bits are treated as 0 (aligned access), and no suppression occurs.

Verification
REQ-017 SW 0xDEADBEEF at 0x10, then next cycle LW 0x10, rd=5 -> two edges later wb_data=0xDEADBEEF, wb_rd=5, wb_reg_write=1.
REQ-018 After REQ-017: LB 0x13 -> wb_data=0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LHU 0x10 -> 0x0000BEEF.
REQ-019 SB 0x55 to 0x11 over word 0xDEADBEEF -> LW 0x10 returns 0xDEAD55EF.
REQ-020 Store issued with stall=1 held 3 cycles then released -> memory unchanged during the stall, one write after release; flush on an entry with reg_write=1 -> wb_reg_write stays 0.
REQ-021 With the macro defined, SW to 0x12 -> misalign_err=1 for one cycle, memory unchanged; with the macro undefined, same stimulus writes word 0x10 and misalign_err=0.
REQ-022 Assert reset with a store in EX/MEM -> no write, all outputs 0 the next cycle.
